branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage pipelined core.
- Sits beside the IF-stage PC. It supplies a predicted next PC from a direct-mapped branch target buffer that has N-bit saturating counters.
- It is trained by branch resolution in ID. It flags mispredictions and supplies the recovery PC that drives the PC mux and the IF/ID flush.
- It replaces the fixed predict-not-taken behaviour and adds hit/mispredict statistics counters.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 16, BTB entries; power of two, >= 2; IDX_BITS = log2(ENTRIES).
- CTR_BITS, 2, saturating counter width, >= 1.
- STAT_BITS, 32, width of statistics counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- pc_i  in  XLEN  current IF PC.
- pred_hit_o  out  1  valid entry with a matching tag for pc_i.
- pred_taken_o  out  1  predicted taken (hit and counter MSB set).
- pred_target_o  out  XLEN  predicted next PC: the stored target if pred_taken_o, else pc_i+4.
- upd_valid_i  in  1  a branch resolved in ID this cycle.
- upd_pc_i  in  XLEN  PC of the resolved branch.
- upd_taken_i  in  1  actual outcome.
- upd_target_i  in  XLEN  actual taken target.
- upd_pred_taken_i  in  1  prediction made for this branch, carried through IF/ID.
- upd_pred_target_i  in  XLEN  predicted next PC carried through IF/ID.
- mispredict_o  out  1  resolution disagrees with the prediction; flush IF/ID and redirect the PC.
- recover_pc_o  out  XLEN  correct next PC when mispredict_o is high.
- branch_cnt_o  out  STAT_BITS  resolved branches.
- mispredict_cnt_o  out  STAT_BITS  mispredictions.

Behaviour:
- Address decode:
  - index = pc[IDX_BITS+1:2].
  - tag = pc[XLEN-1:IDX_BITS+2].
  - pc[1:0] are ignored.
- Storage per entry: valid, tag, target[XLEN], ctr[CTR_BITS]. All are flops; no SRAM.
- Prediction is combinational from pc_i (zero latency):
  - hit = valid[idx] & tag match.
  - taken = hit & ctr[CTR_BITS-1].
- Mispredict (combinational, gated by upd_valid_i):
  - mispredict_o = (upd_taken_i != upd_pred_taken_i) | (upd_taken_i & upd_pred_target_i != upd_target_i).
  - recover_pc_o = upd_taken_i ? upd_target_i : upd_pc_i+4.
  - recover_pc_o is 0 when upd_valid_i is low.
- Update, applied at the posedge when upd_valid_i is high:
  - Hit, taken: ctr increments, saturating at all-ones; target <= upd_target_i.
  - Hit, not taken: ctr decrements, saturating at 0; target is unchanged.
  - Miss, taken: allocate by overwriting idx (replacing any other tag). Set valid=1, write tag and target, ctr = 2^(CTR_BITS-1) (weakly taken).
  - Miss, not taken: no allocation; no state change.
- Statistics, at the posedge:
  - branch_cnt_o increments when upd_valid_i is high.
  - mispredict_cnt_o increments when mispredict_o is high.
  - Both saturate at all-ones and do not wrap.
- Read/write to the same index in the same cycle: the prediction uses the pre-update state (no bypass). The new state is visible the next cycle.
- Reset (async assert, clocked deassert in the system):
  - All valid = 0.
  - ctr = 2^(CTR_BITS-1)-1 (weakly not taken).
  - Targets and tags = 0.
  - Statistics = 0.
  - Hence pred_hit_o = pred_taken_o = 0 and pred_target_o = pc_i+4.
- Reset mid-update: the update is lost and state clears immediately.
- CTR_BITS=1 degenerates to a last-outcome predictor: allocate ctr=1, reset ctr=0.
- No X propagation: outputs are defined whenever inputs are known.

Decomposition:
- Shared package (core pkg):
  - XLEN default.
  - PC increment constant 4.
  - Function clog2.
  - Counter helpers: sat_inc and sat_dec, parametrised by width.
- Sub-module: bp_sat_counter.
  - One N-bit saturating up/down counter with enable and reset value.
  - Instantiated per entry and reused for the statistics counters with a fixed up direction.

Test Plan:
- Reset, then pc_i=0x40 -> hit=0, taken=0, target=0x44, both counts 0.
- Update pc=0x40, taken=1, target=0x80, pred_taken=0 -> mispredict_o=1, recover_pc_o=0x80. Next cycle pc_i=0x40 gives hit=1, taken=1, target=0x80; counts 1/1.
- Update 0x40 not-taken twice, pred_taken matching each time (first 1, then 0):
  - After the first update: ctr 10->01, prediction is not taken, target=0x44.
  - First update: mispredict_o=1, recover_pc_o=0x44.
- Aliasing, ENTRIES=16: 0x40 allocated, then a taken update at 0x440 (same index 0) with target 0x900 -> 0x40 now misses; 0x440 hits and predicts 0x900.
- Counter saturation: five taken updates at 0x40 -> ctr stays 11. One not-taken -> 10, still predicts taken.
- Same-cycle read and update of idx 0 -> pred_* reflects the old state that cycle and the new state the next cycle. Assert rst_i mid-run -> all outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared constants and helpers for the branch predictor: PC step, clog2 and saturating counter math.
// Functions are pure combinational; no state or flow control lives here.
package branch_predictor_pkg;

  localparam int          XLEN_DEF = 32;
  localparam int unsigned PC_INC   = 4;

  function automatic int clog2(input int unsigned n);
    int r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // Counters up to 64 bits share these; w selects the live width.
  function automatic logic [63:0] sat_max(input int unsigned w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    return (v >= sat_max(w)) ? sat_max(w) : v + 64'd1;
  endfunction

  function automatic logic [63:0] sat_dec(input logic [63:0] v, input int unsigned w);
    return (v == 64'd0) ? 64'd0 : v - 64'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter with synchronous load and async reset value.
// Latency: new value visible one clock after en/load; no backpressure.
module bp_sat_counter
  import branch_predictor_pkg::*;
#(
  parameter int            W       = 2,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         up_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (en_i)
      cnt_d = up_i ? W'(sat_inc(64'(cnt_q), W)) : W'(sat_dec(64'(cnt_q), W));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= RST_VAL;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB predictor with per-entry saturating counters, ID-stage training and statistics.
// Latency: prediction and mispredict are combinational; training lands at the next clock; no backpressure.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int ENTRIES   = 16,
  parameter int CTR_BITS  = 2,
  parameter int STAT_BITS = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [XLEN-1:0]      pc_i,
  output logic                 pred_hit_o,
  output logic                 pred_taken_o,
  output logic [XLEN-1:0]      pred_target_o,
  input  logic                 upd_valid_i,
  input  logic [XLEN-1:0]      upd_pc_i,
  input  logic                 upd_taken_i,
  input  logic [XLEN-1:0]      upd_target_i,
  input  logic                 upd_pred_taken_i,
  input  logic [XLEN-1:0]      upd_pred_target_i,
  output logic                 mispredict_o,
  output logic [XLEN-1:0]      recover_pc_o,
  output logic [STAT_BITS-1:0] branch_cnt_o,
  output logic [STAT_BITS-1:0] mispredict_cnt_o
);

  localparam int IDX_BITS = clog2(ENTRIES);
  localparam int TAG_W    = XLEN - IDX_BITS - 2;
  localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_WEAK_T - CTR_BITS'(1);

  logic                 valid_q  [ENTRIES];
  logic                 valid_d  [ENTRIES];
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [TAG_W-1:0]     tag_d    [ENTRIES];
  logic [XLEN-1:0]      target_q [ENTRIES];
  logic [XLEN-1:0]      target_d [ENTRIES];
  logic [ENTRIES-1:0][CTR_BITS-1:0] ctr;

  logic [IDX_BITS-1:0] rd_idx, up_idx;
  logic [TAG_W-1:0]    rd_tag, up_tag;
  logic                up_hit;

  assign rd_idx = pc_i[IDX_BITS+1:2];
  assign rd_tag = pc_i[XLEN-1:IDX_BITS+2];
  assign up_idx = upd_pc_i[IDX_BITS+1:2];
  assign up_tag = upd_pc_i[XLEN-1:IDX_BITS+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Prediction reads only registered state, so a same-cycle update is not bypassed.
  always_comb begin
    pred_hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    pred_taken_o  = pred_hit_o && ctr[rd_idx][CTR_BITS-1];
    pred_target_o = pred_taken_o ? target_q[rd_idx] : pc_i + XLEN'(PC_INC);
  end

  always_comb begin
    mispredict_o = 1'b0;
    recover_pc_o = '0;
    if (upd_valid_i) begin
      mispredict_o = (upd_taken_i != upd_pred_taken_i) ||
                     (upd_taken_i && (upd_pred_target_i != upd_target_i));
      recover_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + XLEN'(PC_INC);
    end
  end

  // A taken resolution either refreshes a hit's target or allocates over the slot.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (upd_valid_i && upd_taken_i) begin
      valid_d[up_idx]  = 1'b1;
      tag_d[up_idx]    = up_tag;
      target_d[up_idx] = upd_target_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    logic sel;
    assign sel = upd_valid_i && (up_idx == IDX_BITS'(g));
    bp_sat_counter #(.W(CTR_BITS), .RST_VAL(CTR_WEAK_NT)) u_ctr (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .en_i       (sel && up_hit),
      .up_i       (upd_taken_i),
      .load_i     (sel && !up_hit && upd_taken_i),
      .load_val_i (CTR_WEAK_T),
      .cnt_o      (ctr[g])
    );
  end

  bp_sat_counter #(.W(STAT_BITS), .RST_VAL('0)) u_branch_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (upd_valid_i),
    .up_i       (1'b1),
    .load_i     (1'b0),
    .load_val_i ('0),
    .cnt_o      (branch_cnt_o)
  );

  bp_sat_counter #(.W(STAT_BITS), .RST_VAL('0)) u_mispredict_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (mispredict_o),
    .up_i       (1'b1),
    .load_i     (1'b0),
    .load_val_i ('0),
    .cnt_o      (mispredict_cnt_o)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expectations (ENTRIES=16, CTR_BITS=2).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = '0;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pred_target = '0;
  logic        mispredict;
  logic [31:0] recover_pc;
  logic [31:0] branch_cnt, mispredict_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  branch_predictor dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .pc_i              (pc),
    .pred_hit_o        (pred_hit),
    .pred_taken_o      (pred_taken),
    .pred_target_o     (pred_target),
    .upd_valid_i       (upd_valid),
    .upd_pc_i          (upd_pc),
    .upd_taken_i       (upd_taken),
    .upd_target_i      (upd_target),
    .upd_pred_taken_i  (upd_pred_taken),
    .upd_pred_target_i (upd_pred_target),
    .mispredict_o      (mispredict),
    .recover_pc_o      (recover_pc),
    .branch_cnt_o      (branch_cnt),
    .mispredict_cnt_o  (mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] p, input logic t, input logic [31:0] tgt,
                     input logic pt, input logic [31:0] ptgt);
    upd_valid = 1'b1; upd_pc = p; upd_taken = t; upd_target = tgt;
    upd_pred_taken = pt; upd_pred_target = ptgt;
    #1;
  endtask

  task automatic idle();
    upd_valid = 1'b0;
    #1;
  endtask

  task automatic pred(input string tag, input logic [31:0] p, input logic h,
                      input logic t, input logic [31:0] tgt);
    pc = p;
    #1;
    check({tag, "_hit"}, 64'(pred_hit), 64'(h));
    check({tag, "_taken"}, 64'(pred_taken), 64'(t));
    check({tag, "_target"}, 64'(pred_target), 64'(tgt));
  endtask

  task automatic counts(input string tag, input int b, input int m);
    check({tag, "_branch_cnt"}, 64'(branch_cnt), 64'(b));
    check({tag, "_mispred_cnt"}, 64'(mispredict_cnt), 64'(m));
  endtask

  initial begin
    #2 rst = 1'b1;
    step();
    pred("reset", 32'h40, 1'b0, 1'b0, 32'h44);
    counts("reset", 0, 0);
    check("reset_mispredict", 64'(mispredict), 64'd0);
    check("reset_recover", 64'(recover_pc), 64'd0);
    rst = 1'b0;
    step();

    // Allocate 0x40 -> 0x80; prediction this cycle still sees the empty entry.
    upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    check("alloc_mispredict", 64'(mispredict), 64'd1);
    check("alloc_recover", 64'(recover_pc), 64'h80);
    pred("alloc_same_cycle", 32'h40, 1'b0, 1'b0, 32'h44);
    step(); idle();
    pred("alloc_next", 32'h40, 1'b1, 1'b1, 32'h80);
    counts("alloc", 1, 1);

    upd(32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
    check("nt1_mispredict", 64'(mispredict), 64'd1);
    check("nt1_recover", 64'(recover_pc), 64'h44);
    step(); idle();
    pred("nt1", 32'h40, 1'b1, 1'b0, 32'h44);
    counts("nt1", 2, 2);

    upd(32'h40, 1'b0, 32'h80, 1'b0, 32'h44);
    check("nt2_mispredict", 64'(mispredict), 64'd0);
    check("nt2_recover", 64'(recover_pc), 64'h44);
    step(); idle();
    pred("nt2", 32'h40, 1'b1, 1'b0, 32'h44);
    counts("nt2", 3, 2);

    // Counter 00 -> 11, then held at 11 across the extra taken updates.
    for (int i = 0; i < 5; i++) begin
      upd(32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
      check("sat_mispredict", 64'(mispredict), 64'd0);
      step();
    end
    idle();
    pred("sat", 32'h40, 1'b1, 1'b1, 32'h80);
    counts("sat", 8, 2);
    upd(32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
    step(); idle();
    pred("sat_dec", 32'h40, 1'b1, 1'b1, 32'h80);
    counts("sat_dec", 9, 3);

    upd(32'h40, 1'b1, 32'h84, 1'b1, 32'h80);
    check("tgt_mispredict", 64'(mispredict), 64'd1);
    check("tgt_recover", 64'(recover_pc), 64'h84);
    step(); idle();
    pred("tgt", 32'h40, 1'b1, 1'b1, 32'h84);
    counts("tgt", 10, 4);

    // 0x440 shares index 0 with 0x40 and evicts it.
    upd(32'h440, 1'b1, 32'h900, 1'b0, 32'h444);
    check("alias_mispredict", 64'(mispredict), 64'd1);
    pred("alias_same_cycle", 32'h40, 1'b1, 1'b1, 32'h84);
    step(); idle();
    pred("alias_old", 32'h40, 1'b0, 1'b0, 32'h44);
    pred("alias_new", 32'h440, 1'b1, 1'b1, 32'h900);
    counts("alias", 11, 5);

    upd(32'h48, 1'b0, 32'h0, 1'b0, 32'h4c);
    check("miss_nt_mispredict", 64'(mispredict), 64'd0);
    check("miss_nt_recover", 64'(recover_pc), 64'h4c);
    step(); idle();
    pred("miss_nt", 32'h48, 1'b0, 1'b0, 32'h4c);
    counts("miss_nt", 12, 5);

    // Async reset mid-cycle with an update pending; that update must be lost.
    pc = 32'h440;
    upd(32'h440, 1'b1, 32'h900, 1'b1, 32'h900);
    #1 rst = 1'b1;
    #1;
    pred("arst", 32'h440, 1'b0, 1'b0, 32'h444);
    counts("arst", 0, 0);
    step();
    idle();
    rst = 1'b0;
    step();
    pred("post_rst", 32'h440, 1'b0, 1'b0, 32'h444);
    counts("post_rst", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
